// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch-stage PC sequencing, redirect arbitration and halt control
//
// Purpose:
//   Drives the next value (pc3) and load enable (pc_en) of the fetch PC
//   register every cycle. Chooses between sequential advance (npc) and the
//   branch / jump-register / jump redirect sources (fixed priority br > jr > j).
//   A redirect that arrives while the I-cache is missing is held in
//   pend_target until ihit. Halt freezes the controller until reset.
//   Cycles in which the PC does not advance are counted in stall_cnt.
//
// Ports:
//   CLK            system clock, rising edge
//   RST            asynchronous active-high reset
//   npc            sequential next PC (PC+4)
//   ihit           instruction cache hit this cycle
//   stall          hazard-unit stall request for fetch
//   halt           halt instruction reached decode/commit
//   br_req/br_target   taken-branch redirect
//   jr_req/jr_target   jump-register redirect
//   j_req/j_target     jump redirect
//   pc3            next value for the PC register (combinational)
//   pc_en          PC register load enable (combinational)
//   iflush         one-cycle IF/ID flush, only with a committed redirect
//   halted         controller is in HALTED
//   redir_pending  a redirect is held, awaiting ihit
//   stall_cnt      saturating count of non-advancing RUN/PEND cycles

module pc_fetch_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [PC_W-1:0]  npc,
  input  logic             ihit,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_req,
  input  logic [PC_W-1:0]  br_target,
  input  logic             jr_req,
  input  logic [PC_W-1:0]  jr_target,
  input  logic             j_req,
  input  logic [PC_W-1:0]  j_target,
  output logic [PC_W-1:0]  pc3,
  output logic             pc_en,
  output logic             iflush,
  output logic             halted,
  output logic             redir_pending,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pend_target;

  logic            new_req;
  logic [PC_W-1:0] sel_tgt;
  logic [PC_W-1:0] new_tgt;
  logic            count_en;

  // Redirect arbitration: branch beats jump-register beats jump.
  always_comb begin
    new_req = br_req | jr_req | j_req;
    if (br_req)      sel_tgt = br_target;
    else if (jr_req) sel_tgt = jr_target;
    else             sel_tgt = j_target;
    // Targets are word aligned; low bits are forced clear.
    new_tgt = {sel_tgt[PC_W-1:2], 2'b00};
  end

  // PC next-value and enable. RST gates the enable because these outputs
  // depend on live inputs, not only on the (already reset) state.
  always_comb begin
    pc3    = npc;
    pc_en  = 1'b0;
    iflush = 1'b0;
    if (!RST && !halt) begin
      case (state)
        RUN: begin
          if (new_req) begin
            if (ihit) begin
              pc3    = new_tgt;
              pc_en  = 1'b1;
              iflush = 1'b1;
            end
          end else if (ihit && !stall) begin
            pc_en = 1'b1;
          end
        end
        PEND: begin
          // stall is ignored here: the redirected path squashes the stalled
          // instruction anyway. A fresh request this cycle wins over the
          // held one.
          if (ihit) begin
            pc3    = new_req ? new_tgt : pend_target;
            pc_en  = 1'b1;
            iflush = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign halted        = (state == HALTED);
  assign redir_pending = (state == PEND);

  // The cycle that takes halt is the entry into HALTED and is not counted
  // as a stall; only genuine non-advancing RUN/PEND cycles are.
  assign count_en = (state != HALTED) && !halt && !pc_en;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      pend_target <= '0;
      stall_cnt   <= '0;
    end else begin
      if (count_en && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);

      case (state)
        RUN: begin
          if (halt) begin
            state <= HALTED;
          end else if (new_req && !ihit) begin
            pend_target <= new_tgt;
            state       <= PEND;
          end
        end
        PEND: begin
          if (halt) begin
            state       <= HALTED;
            pend_target <= '0;
          end else if (ihit) begin
            state <= RUN;
          end else if (new_req) begin
            pend_target <= new_tgt;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard bench for pc_fetch_ctrl

module tb_pc_fetch_ctrl;

  localparam int PC_W    = 32;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK;
  logic             RST;
  logic [PC_W-1:0]  npc;
  logic             ihit, stall, halt;
  logic             br_req, jr_req, j_req;
  logic [PC_W-1:0]  br_target, jr_target, j_target;
  logic [PC_W-1:0]  pc3;
  logic             pc_en, iflush, halted, redir_pending;
  logic [CNT_W-1:0] stall_cnt;

  pc_fetch_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .npc(npc), .ihit(ihit), .stall(stall), .halt(halt),
    .br_req(br_req), .br_target(br_target),
    .jr_req(jr_req), .jr_target(jr_target),
    .j_req(j_req), .j_target(j_target),
    .pc3(pc3), .pc_en(pc_en), .iflush(iflush), .halted(halted),
    .redir_pending(redir_pending), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [PC_W-1:0] pc3;
    logic            pc_en;
    logic            iflush;
    logic            halted;
    logic            pend;
    int              cnt;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model: "held" redirect is a queue of at most one target,
  // frozen is a sticky flag, the counter is a plain integer.
  bit              m_frozen = 0;
  logic [PC_W-1:0] m_held[$];
  int              m_cnt = 0;
  logic [PC_W-1:0] npc_v = '0;

  task automatic chk(input string name, input logic [PC_W-1:0] act, input logic [PC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per cycle the DUT presents outputs.
  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc_en", PC_W'(pc_en), PC_W'(e.pc_en));
      chk("iflush", PC_W'(iflush), PC_W'(e.iflush));
      chk("halted", PC_W'(halted), PC_W'(e.halted));
      chk("redir_pending", PC_W'(redir_pending), PC_W'(e.pend));
      chk("stall_cnt", PC_W'(stall_cnt), PC_W'(e.cnt));
      chk("pc3", pc3, e.pc3);
    end
  end

  task automatic step(input bit rst, input bit ih, input bit st, input bit hl,
                      input bit br, input logic [PC_W-1:0] brt,
                      input bit jr, input logic [PC_W-1:0] jrt,
                      input bit j,  input logic [PC_W-1:0] jt);
    exp_t e;
    bit nr;
    logic [PC_W-1:0] nt;
    @(posedge CLK);
    #1;
    npc_v = npc_v + 4;
    RST = rst; ihit = ih; stall = st; halt = hl;
    br_req = br; br_target = brt; jr_req = jr; jr_target = jrt; j_req = j; j_target = jt;
    npc = npc_v;

    nr = br | jr | j;
    nt = br ? brt : (jr ? jrt : jt);
    nt = nt & ~PC_W'(3);

    e.pc3 = npc_v; e.pc_en = 0; e.iflush = 0;
    e.halted = m_frozen; e.pend = (m_held.size() != 0); e.cnt = m_cnt;
    if (rst) begin
      e.halted = 0; e.pend = 0; e.cnt = 0;
      m_frozen = 0; m_held.delete(); m_cnt = 0;
    end else if (!m_frozen) begin
      if (hl) begin
        m_frozen = 1;
        m_held.delete();
      end else if (m_held.size() != 0) begin
        if (ih) begin
          e.pc3 = nr ? nt : m_held[0];
          e.pc_en = 1; e.iflush = 1;
          m_held.delete();
        end else if (nr) begin
          m_held.delete();
          m_held.push_back(nt);
        end
      end else if (nr) begin
        if (ih) begin
          e.pc3 = nt; e.pc_en = 1; e.iflush = 1;
        end else begin
          m_held.push_back(nt);
        end
      end else if (ih && !st) begin
        e.pc_en = 1;
      end
      if (!hl && !e.pc_en && m_cnt < CNT_MAX) m_cnt++;
    end
    sb.push_back(e);
  endtask

  task automatic idle(input bit ih, input bit st);
    step(0, ih, st, 0, 0, '0, 0, '0, 0, '0);
  endtask

  initial begin
    RST = 1; npc = '0; ihit = 0; stall = 0; halt = 0;
    br_req = 0; jr_req = 0; j_req = 0;
    br_target = '0; jr_target = '0; j_target = '0;

    // Reset, then sequential fetch 0x4, 0x8, ...
    step(1, 0, 0, 0, 0, '0, 0, '0, 0, '0);
    step(1, 1, 0, 0, 0, '0, 0, '0, 0, '0);
    npc_v = '0;
    repeat (5) idle(1, 0);

    // Priority br over j, and target alignment.
    step(0, 1, 0, 0, 1, 32'h100, 0, '0, 1, 32'h200);
    step(0, 1, 0, 0, 1, 32'h103, 0, '0, 0, '0);

    // jr held through three misses, committed on hit.
    repeat (3) step(0, 0, 0, 0, 0, '0, 1, 32'h40, 0, '0);
    idle(1, 0);

    // Newer request overwrites the held one.
    step(0, 0, 0, 0, 0, '0, 1, 32'h40, 0, '0);
    step(0, 0, 0, 0, 0, '0, 0, '0, 1, 32'h80);
    idle(1, 0);

    // Stalls, then halt beats a branch; stays halted until reset.
    step(1, 0, 0, 0, 0, '0, 0, '0, 0, '0);
    repeat (2) idle(1, 1);
    step(0, 1, 0, 1, 1, 32'h300, 0, '0, 0, '0);
    repeat (3) idle(1, 0);
    step(1, 1, 0, 0, 0, '0, 0, '0, 0, '0);
    idle(1, 0);

    // Reset in PEND drops the held redirect.
    step(0, 0, 0, 0, 0, '0, 1, 32'h44, 0, '0);
    step(1, 1, 0, 0, 0, '0, 0, '0, 0, '0);
    repeat (2) idle(1, 0);

    // Counter saturation.
    repeat (CNT_MAX + 8) idle(1, 1);
    idle(1, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      npc_v = $urandom() & ~PC_W'(3);
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 149) == 0,
           $urandom_range(0, 5) == 0, PC_W'($urandom()),
           $urandom_range(0, 5) == 0, PC_W'($urandom()),
           $urandom_range(0, 5) == 0, PC_W'($urandom()));
    end

    @(negedge CLK);
    #1;
    chk("scoreboard_drained", PC_W'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequences the fetch-stage PC register: drives its next-value (pc3) and enable (pc_en) each cycle.
- Arbitrates between sequential advance and three redirect sources: branch, jump and jump-register.
- Holds a redirect that arrives while the instruction cache is missing, and enforces halt.
- Counts stall cycles for performance analysis.

Parameters:
PC_W, 32, width of PC, npc and all targets
CNT_W, 32, width of the stall-cycle counter

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-high reset
npc  in  PC_W  sequential next PC (PC+4) from the PC register
ihit  in  1  instruction cache hit this cycle
stall  in  1  hazard-unit stall request for fetch
halt  in  1  halt instruction reached decode/commit
br_req  in  1  taken-branch redirect request
br_target  in  PC_W  branch target
jr_req  in  1  jump-register redirect request
jr_target  in  PC_W  register target
j_req  in  1  jump redirect request
j_target  in  PC_W  jump target
pc3  out  PC_W  next value for the PC register
pc_en  out  1  PC register load enable
iflush  out  1  one-cycle flush of the IF/ID latch
halted  out  1  controller is in HALTED
redir_pending  out  1  a redirect is held, awaiting ihit
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0 while in RUN or PEND

Behaviour:
Reset (RST=1, asynchronous):
- state=RUN; pending register and pend_target cleared to 0; stall_cnt=0.
- Outputs during and after reset: pc_en=0, iflush=0, halted=0, redir_pending=0, pc3=npc (combinational).

Redirect selection (combinational), fixed priority br > jr > j:
- new_req = br_req|jr_req|j_req.
- new_tgt = the target of the winning request, with bits [1:0] forced to 0.

FSM states: RUN, PEND, HALTED.

RUN:
- halt=1: go to HALTED; pc_en=0; any request that cycle is discarded.
- new_req=1 and ihit=1: pc3=new_tgt, pc_en=1, iflush=1; stay in RUN.
- new_req=1 and ihit=0: latch new_tgt into pend_target; go to PEND; pc_en=0.
- No request, ihit=1 and stall=0: pc3=npc, pc_en=1.
- Otherwise: pc_en=0.

PEND (redir_pending=1):
- halt=1: go to HALTED; the pending redirect is dropped.
- new_req=1: new_tgt overwrites pend_target. If ihit=1 the same cycle, commit new_tgt directly.
- ihit=1: pc3=pend_target (or new_tgt per the rule above), pc_en=1, iflush=1; return to RUN.
- stall is ignored in PEND, because the redirected path squashes the stalled instruction.
- ihit=0: pc_en=0; remain in PEND.

HALTED:
- pc_en=0, iflush=0, halted=1. All inputs are ignored until RST.

Outputs and counters:
- pc3 equals npc whenever no redirect commits. pc3 is combinational; pc_en is combinational from state and inputs.
- iflush is asserted only in a cycle where pc_en=1 with a redirect target.
- stall_cnt increments by 1 each RUN/PEND cycle with pc_en=0. It saturates at all-ones and never increments in HALTED.
- halt has precedence over every redirect and over ihit.
- RST asserted mid-PEND discards pend_target immediately; there is no commit after reset release.

Test Plan:
- Reset, then ihit=1, stall=0, npc=0x4,0x8,... -> pc_en=1 every cycle, pc3=npc, iflush=0, stall_cnt=0.
- In RUN: ihit=1, br_req=1 (br_target=0x100), j_req=1 (j_target=0x200) same cycle -> pc3=0x100, pc_en=1, iflush=1; target 0x103 -> pc3=0x100.
- jr_req=1 (0x40) with ihit=0 for 3 cycles, then ihit=1 -> redir_pending=1 for 3 cycles, pc_en=0, stall_cnt=3; 4th cycle pc3=0x40, iflush=1, back to RUN.
- In PEND with target 0x40: j_req=1 (0x80) while ihit=0, then ihit=1 -> pc3=0x80, iflush=1, not 0x40.
- stall=1, ihit=1 for 2 cycles, then halt=1 with br_req=1 -> pc_en=0 throughout, stall_cnt=2, halted=1. Stays halted with ihit=1 until RST=1, then all outputs return to their reset values.
- RST pulsed while in PEND -> redir_pending=0 immediately; after release with ihit=1, pc3=npc, iflush=0.
